fifo_stream_out: RTL

Read-side adapter that sits directly downstream of the synchronous FIFO and drains it into a valid/ready output stream. It issues FIFO pops only when it has buffer space, holds up to two words in an internal two-entry output buffer, and frames the stream into fixed-length packets with a last flag. This gives full throughput under continuous ready while no combinational path runs from the downstream ready to the FIFO pop.

---
 rtl/fifo_stream_out.sv | 99 +++++++++
 1 files changed

// File: rtl/fifo_stream_out.sv
// Drains a synchronous FIFO into a valid/ready stream through a two-entry buffer
// and frames it into PKT_LEN-beat packets. Optional word counter: STREAM_OUT_CNT_EN.
module fifo_stream_out #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_rd,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef STREAM_OUT_CNT_EN
    ,
    output logic [15:0]           word_cnt
`endif
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  push;
    logic                  accept;

    // Pop decision uses only registered occupancy, so m_ready never reaches fifo_rd.
    always_comb begin
        push    = ~reset & ~fifo_empty & (cnt_q != 2'd2);
        fifo_rd = push;
        m_valid = (cnt_q != 2'd0);
        accept  = m_valid & m_ready;
        m_data  = head_q;
        m_last  = m_valid & (beat_q == LAST_BEAT);
    end

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        beat_d = beat_q;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, accept};

        if (accept && (cnt_q == 2'd2)) begin
            head_d = skid_q;
        end
        if (push) begin
            if ((cnt_q == 2'd0) || accept) begin
                head_d = fifo_r_data;
            end else begin
                skid_d = fifo_r_data;
            end
        end

        if (accept) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= 2'd0;
            beat_q <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
        end
    end

`ifdef STREAM_OUT_CNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (accept) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q <= 16'd0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule
